mole_game_ctrl: RTL and testbench



---
 rtl/mole_game_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mole_game_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game sequencer: paces play from the 1 Hz strobe, places moles,
// scores hits in BCD and counts down the game clock. All outputs are registered.
module mole_game_ctrl #(
  parameter int NUM_HOLES  = 9,
  parameter int GAME_SECS  = 30,
  parameter int MOLE_TICKS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_1hz,
  input  logic                 start_btn,
  input  logic [NUM_HOLES-1:0] hit_btn,
  input  logic [3:0]           pos_in,
  output logic                 in_game,
  output logic                 mole_on,
  output logic [3:0]           mole_pos,
  output logic [3:0]           score_tens,
  output logic [3:0]           score_ones,
  output logic [3:0]           time_tens,
  output logic [3:0]           time_ones,
  output logic [7:0]           miss_cnt,
  output logic                 game_over,
  output logic [2:0]           state_dbg
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_SHOW = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_OVER = 3'd4;

  localparam logic [3:0] SECS_TENS = 4'(GAME_SECS / 10);
  localparam logic [3:0] SECS_ONES = 4'(GAME_SECS % 10);
  localparam logic [3:0] LIFE_INIT = 4'(MOLE_TICKS);
  localparam logic [4:0] HOLES_W   = 5'(NUM_HOLES);
  localparam logic [3:0] HOLES_N   = 4'(NUM_HOLES);

  logic [2:0]           state;
  logic                 start_prev;
  logic [NUM_HOLES-1:0] hit_prev;
  logic                 edge_en;
  logic [3:0]           life;

  logic                 start_edge;
  logic [NUM_HOLES-1:0] hit_edge;
  logic [NUM_HOLES-1:0] pos_mask;
  logic                 good_hit;
  logic                 wrong_hit;
  logic                 final_tick;
  logic [3:0]           pos_fold;
  logic [3:0]           time_tens_dec;
  logic [3:0]           time_ones_dec;
  logic [3:0]           score_tens_inc;
  logic [3:0]           score_ones_inc;

  assign state_dbg = state;

  // edge_en masks the first cycle after reset so a level held through reset is not an edge
  assign start_edge = edge_en & start_btn & ~start_prev;
  assign hit_edge   = {NUM_HOLES{edge_en}} & hit_btn & ~hit_prev;

  always_comb begin
    pos_mask = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      pos_mask[i] = (mole_pos == 4'(i));
    end
  end

  assign good_hit   = |(hit_edge & pos_mask);
  assign wrong_hit  = |(hit_edge & ~pos_mask);
  assign final_tick = tick_1hz && (time_tens == 4'd0) && (time_ones == 4'd1);

  // With 16 holes HOLES_N wraps to 0 and the compare never folds, which is correct.
  assign pos_fold = ({1'b0, pos_in} < HOLES_W) ? pos_in : pos_in - HOLES_N;

  always_comb begin
    time_tens_dec = time_tens;
    time_ones_dec = time_ones - 4'd1;
    if (time_ones == 4'd0) begin
      time_ones_dec = 4'd9;
      time_tens_dec = time_tens - 4'd1;
    end
  end

  always_comb begin
    score_tens_inc = score_tens;
    score_ones_inc = score_ones;
    if (!(score_tens == 4'd9 && score_ones == 4'd9)) begin
      if (score_ones == 4'd9) begin
        score_ones_inc = 4'd0;
        score_tens_inc = score_tens + 4'd1;
      end else begin
        score_ones_inc = score_ones + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      start_prev <= 1'b0;
      hit_prev   <= '0;
      edge_en    <= 1'b0;
      life       <= 4'd0;
      in_game    <= 1'b0;
      mole_on    <= 1'b0;
      mole_pos   <= 4'd0;
      score_tens <= 4'd0;
      score_ones <= 4'd0;
      time_tens  <= 4'd0;
      time_ones  <= 4'd0;
      miss_cnt   <= 8'd0;
      game_over  <= 1'b0;
    end else begin
      start_prev <= start_btn;
      hit_prev   <= hit_btn;
      edge_en    <= 1'b1;
      case (state)
        S_IDLE, S_OVER: begin
          if (start_edge) begin
            state      <= S_ARM;
            time_tens  <= SECS_TENS;
            time_ones  <= SECS_ONES;
            score_tens <= 4'd0;
            score_ones <= 4'd0;
            miss_cnt   <= 8'd0;
            in_game    <= 1'b1;
            mole_on    <= 1'b0;
            game_over  <= 1'b0;
          end
        end
        S_ARM, S_SHOW, S_GAP: begin
          if (state == S_SHOW) begin
            if (good_hit) begin
              score_tens <= score_tens_inc;
              score_ones <= score_ones_inc;
            end
            if (wrong_hit && miss_cnt != 8'hff) miss_cnt <= miss_cnt + 8'd1;
          end
          if (tick_1hz) begin
            time_tens <= time_tens_dec;
            time_ones <= time_ones_dec;
          end
          // The final tick wins over every other transition in the same cycle.
          if (final_tick) begin
            state     <= S_OVER;
            in_game   <= 1'b0;
            mole_on   <= 1'b0;
            game_over <= 1'b1;
          end else if (state == S_SHOW) begin
            if (good_hit) begin
              state   <= S_GAP;
              mole_on <= 1'b0;
            end else if (tick_1hz) begin
              life <= life - 4'd1;
              if (life == 4'd1) begin
                state   <= S_GAP;
                mole_on <= 1'b0;
              end
            end
          end else if (tick_1hz) begin
            state    <= S_SHOW;
            mole_on  <= 1'b1;
            mole_pos <= pos_fold;
            life     <= LIFE_INIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: directed steps plus a randomized stretch, all checked
// against a rule-level game model.
module tb_mole_game_ctrl;
  localparam int NH = 9;
  localparam int GS = 30;
  localparam int MT = 2;
  localparam int W  = 31;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick_1hz;
  logic          start_btn;
  logic [NH-1:0] hit_btn;
  logic [3:0]    pos_in;
  logic          in_game;
  logic          mole_on;
  logic [3:0]    mole_pos;
  logic [3:0]    score_tens;
  logic [3:0]    score_ones;
  logic [3:0]    time_tens;
  logic [3:0]    time_ones;
  logic [7:0]    miss_cnt;
  logic          game_over;
  logic [2:0]    state_dbg;

  always #10 clk = ~clk;

  mole_game_ctrl #(.NUM_HOLES(NH), .GAME_SECS(GS), .MOLE_TICKS(MT)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .start_btn(start_btn),
    .hit_btn(hit_btn), .pos_in(pos_in), .in_game(in_game), .mole_on(mole_on),
    .mole_pos(mole_pos), .score_tens(score_tens), .score_ones(score_ones),
    .time_tens(time_tens), .time_ones(time_ones), .miss_cnt(miss_cnt),
    .game_over(game_over), .state_dbg(state_dbg)
  );

  typedef enum {M_IDLE, M_ARM, M_SHOW, M_GAP, M_OVER} mphase_t;
  mphase_t       m_phase;
  int            m_secs, m_score, m_miss, m_pos, m_life;
  bit            m_seen;
  logic          m_ps;
  logic [NH-1:0] m_ph;

  int         checks = 0;
  int         errors = 0;
  logic [W-1:0] exp_q[$];

  function automatic void model_reset();
    m_phase = M_IDLE;
    m_secs = 0; m_score = 0; m_miss = 0; m_pos = 0; m_life = 0;
    m_seen = 0; m_ps = 1'b0; m_ph = '0;
  endfunction

  function automatic void model_step(input bit t, input bit s, input logic [NH-1:0] h,
                                     input int p);
    logic [NH-1:0] he;
    bit se, good, wrong;
    se = m_seen && s && !m_ps;
    he = m_seen ? (h & ~m_ph) : '0;
    m_ps = s; m_ph = h; m_seen = 1;
    good = 0; wrong = 0;
    if (m_phase == M_IDLE || m_phase == M_OVER) begin
      if (se) begin
        m_phase = M_ARM; m_secs = GS; m_score = 0; m_miss = 0;
      end
    end else begin
      if (m_phase == M_SHOW) begin
        for (int i = 0; i < NH; i++)
          if (he[i]) begin
            if (i == m_pos) good = 1; else wrong = 1;
          end
        if (good && m_score < 99) m_score++;
        if (wrong && m_miss < 255) m_miss++;
      end
      if (t) m_secs--;
      if (t && m_secs == 0) m_phase = M_OVER;
      else if (m_phase == M_SHOW) begin
        if (good) m_phase = M_GAP;
        else if (t) begin
          m_life--;
          if (m_life == 0) m_phase = M_GAP;
        end
      end else if (t) begin
        m_pos = (p < NH) ? p : p - NH;
        m_life = MT;
        m_phase = M_SHOW;
      end
    end
  endfunction

  function automatic logic [W-1:0] model_vec();
    bit ig;
    ig = (m_phase == M_ARM || m_phase == M_SHOW || m_phase == M_GAP);
    return {ig, (m_phase == M_SHOW), 4'(m_pos), 4'(m_score / 10), 4'(m_score % 10),
            4'(m_secs / 10), 4'(m_secs % 10), 8'(m_miss), (m_phase == M_OVER)};
  endfunction

  task automatic check(input string tag);
    logic [W-1:0] got, exp;
    exp_q.push_back(model_vec());
    exp = exp_q.pop_front();
    got = {in_game, mole_on, mole_pos, score_tens, score_ones, time_tens, time_ones,
           miss_cnt, game_over};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input bit t, input bit s, input logic [NH-1:0] h, input int p,
                      input string tag);
    tick_1hz = t; start_btn = s; hit_btn = h; pos_in = 4'(p);
    @(posedge clk);
    model_step(t, s, h, p);
    #1;
    check(tag);
  endtask

  initial begin
    bit            rt;
    int            rsel, guard;
    logic [NH-1:0] rh;

    rst = 1'b0; tick_1hz = 1'b0; start_btn = 1'b1; hit_btn = '0; pos_in = 4'd0;
    model_reset();
    #5;
    check("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    // start held high through reset release must not start a game
    for (int i = 0; i < 3; i++) step(0, 1, '0, 0, "hold_start");
    step(0, 0, '0, 0, "start_low");
    step(0, 1, '0, 0, "start_edge");
    step(1, 1, '0, 4, "tick_pos4");
    step(0, 0, NH'(1 << 4), 0, "hit4");
    step(0, 0, '0, 0, "release");
    step(0, 0, NH'(1 << 4), 0, "hit4_gap");
    step(0, 0, '0, 0, "release");

    step(1, 0, '0, 12, "tick_pos12");
    step(0, 0, NH'(1 << 0), 0, "wrong0");
    step(0, 0, '0, 0, "release");
    step(0, 0, NH'(1 << 2), 0, "wrong2");
    step(0, 0, '0, 0, "release");
    step(1, 0, '0, 0, "life_tick1");
    step(1, 0, '0, 8, "life_tick2");
    step(1, 0, '0, 8, "tick_pos8");

    guard = 0;
    while (m_secs > 2 && guard < 3000) begin
      rt = ($urandom_range(0, 3) == 0);
      rsel = $urandom_range(0, 3);
      case (rsel)
        0: rh = '0;
        1: rh = NH'(1 << m_pos);
        2: rh = NH'($urandom);
        default: rh = hit_btn;
      endcase
      step(rt, $urandom_range(0, 1) == 1, rh, $urandom_range(0, 15), "rand");
      guard++;
    end
    checks++;
    assert (time_tens === 4'd0 && time_ones === 4'd2) else begin
      errors++;
      $error("FAIL rand_budget got=%0d%0d exp=02", time_tens, time_ones);
    end

    step(0, 0, '0, 0, "pre_final_release");
    if (m_phase == M_SHOW) begin
      step(0, 0, NH'(1 << m_pos), 0, "pre_final_hit");
      step(0, 0, '0, 0, "pre_final_release2");
    end
    step(1, 0, '0, 6, "tick_to_01");
    step(1, 0, NH'(1 << 6), 0, "final_tick_hit");
    for (int i = 0; i < 3; i++) step(1, 0, NH'(1 << i), 3, "after_over");
    step(0, 1, '0, 0, "restart");
    step(1, 1, '0, 5, "tick_pos5");

    for (int i = 0; i < 260; i++) begin
      step(0, 0, NH'(1 << 0), 0, "miss_sat_on");
      step(0, 0, '0, 0, "miss_sat_off");
    end

    force dut.score_tens = 4'd9;
    force dut.score_ones = 4'd9;
    #1;
    release dut.score_tens;
    release dut.score_ones;
    m_score = 99;
    step(0, 0, NH'(1 << 5), 0, "score_sat_hit");
    step(0, 0, '0, 0, "release");
    step(1, 0, '0, 7, "tick_pos7");

    // asynchronous reset mid-SHOW, sampled away from any clock edge
    rst = 1'b0;
    #2;
    model_reset();
    check("async_reset");
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, "post_reset_idle");

    $display("final state code %0d", state_dbg);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
